// File: rtl/ysyx_22050612_mem_responder.sv
// ysyx_22050612_mem_responder: handshaked 64-bit word memory responder for LSU traffic.
// One request in flight; response presented LAT cycles after accept, held until taken.
`default_nettype none

module ysyx_22050612_mem_responder #(
  parameter int          DEPTH = 1024,
  parameter logic [63:0] BASE  = 64'h8000_0000,
  parameter int          LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          c_AW       = $clog2(DEPTH);
  localparam logic [63:0] c_LIMIT    = BASE + 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  c_CNT_INIT = 4'(LAT - 1);

  // S_LAST is the cycle whose closing edge performs the array access and enters S_RESP.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [3:0]      r_cnt;
  logic            r_wen;
  logic [63:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [7:0]      r_wmask;
  logic [63:0]     r_rdata;
  logic            r_err;
  logic [63:0]     r_mem [DEPTH];
  logic            w_accept;
  logic            w_in_range;
  logic [c_AW-1:0] w_idx;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_in_range = (r_addr >= BASE) && (r_addr < c_LIMIT);
  assign w_idx      = r_addr[c_AW+2:3] - BASE[c_AW+2:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (LAT > 1) ? S_WAIT : S_LAST;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = S_LAST;
        end
      end
      S_LAST: w_next = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    resp_rdata = r_rdata;
    resp_err   = r_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_wen   <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_wmask <= 8'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= c_CNT_INIT;
        r_wen   <= req_wen;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wmask <= req_wmask;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_LAST) begin
        r_err   <= !w_in_range;
        r_rdata <= (w_in_range && !r_wen) ? r_mem[w_idx] : 64'd0;
      end
    end
  end

  // Array has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if ((r_state == S_LAST) && w_in_range && r_wen) begin
      for (int b = 0; b < 8; b++) begin
        if (r_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050612_mem_responder.sv
// tb_ysyx_22050612_mem_responder: directed checks of a LAT=2 and a LAT=1 responder.
`default_nettype none

module tb_ysyx_22050612_mem_responder;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_wen;
  logic [1:0][63:0] req_addr;
  logic [1:0][63:0] req_wdata;
  logic [1:0][7:0]  req_wmask;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [1:0][63:0] resp_rdata;
  logic [1:0]       resp_err;

  int n_vec;
  int n_err;

  ysyx_22050612_mem_responder #(.DEPTH(1024), .BASE(64'h8000_0000), .LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  ysyx_22050612_mem_responder #(.DEPTH(1024), .BASE(64'h8000_0000), .LAT(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full transaction; caller is positioned #1 after an edge with the DUT idle.
  task automatic xact(input int s, input logic wen, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask,
                      input int exp_lat, input logic [63:0] exp_rdata,
                      input logic exp_err, input string tag);
    int n;
    check({tag, "_rdy"}, 64'(req_ready[s]), 64'd1);
    req_valid[s] = 1'b1;
    req_wen[s]   = wen;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    req_wmask[s] = wmask;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    n = 0;
    while (!resp_valid[s] && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_rdata"}, resp_rdata[s], exp_rdata);
    check({tag, "_err"}, 64'(resp_err[s]), 64'(exp_err));
    resp_ready[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready[s] = 1'b0;
  endtask

  initial begin
    logic [8:0]  pat;
    logic [63:0] held;
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_wen    = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(resp_valid[0]), 64'd0);
    check("rst_rdata", resp_rdata[0], 64'd0);
    check("rst_err", 64'(resp_err[0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 64'(req_ready[0]), 64'd1);

    // Full write then read back
    xact(0, 1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 2, 64'd0, 1'b0, "w_full");
    xact(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 2, 64'h1122334455667788, 1'b0, "r_full");

    // Partial strobe and zero-mask no-op
    xact(0, 1'b1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2, 64'd0, 1'b0, "w_pre");
    xact(0, 1'b1, 64'h8000_0020, 64'h0000_AB00_0000_0000, 8'h20, 2, 64'd0, 1'b0, "w_part");
    xact(0, 1'b0, 64'h8000_0020, 64'd0, 8'h00, 2, 64'hFFFF_ABFF_FFFF_FFFF, 1'b0, "r_part");
    xact(0, 1'b1, 64'h8000_0020, 64'd0, 8'h00, 2, 64'd0, 1'b0, "w_nomask");
    xact(0, 1'b0, 64'h8000_0020, 64'd0, 8'h00, 2, 64'hFFFF_ABFF_FFFF_FFFF, 1'b0, "r_nomask");

    // Range boundaries
    xact(0, 1'b1, 64'h8000_0000, 64'hDEADBEEF_CAFEF00D, 8'hFF, 2, 64'd0, 1'b0, "w_word0");
    xact(0, 1'b1, 64'h8000_1FF8, 64'h0102030405060708, 8'hFF, 2, 64'd0, 1'b0, "w_last");
    xact(0, 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 2, 64'h0102030405060708, 1'b0, "r_last");
    xact(0, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 2, 64'd0, 1'b1, "r_below");
    xact(0, 1'b0, 64'h8000_2000, 64'd0, 8'h00, 2, 64'd0, 1'b1, "r_above");
    xact(0, 1'b1, 64'h8000_2000, 64'h5555_5555_5555_5555, 8'hFF, 2, 64'd0, 1'b1, "w_above");
    xact(0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 2, 64'hDEADBEEF_CAFEF00D, 1'b0, "r_word0");

    // Backpressure: response held, competing request ignored
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b0;
    req_addr[0]  = 64'h8000_0010;
    @(posedge clk); #1;
    req_wen[0]   = 1'b1;
    req_wdata[0] = 64'd0;
    req_wmask[0] = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    held = resp_rdata[0];
    check("bp_first", held, 64'h1122334455667788);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(resp_valid[0]), 64'd1);
      check("bp_rdata", resp_rdata[0], 64'h1122334455667788);
      check("bp_ready", 64'(req_ready[0]), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready[0] = 1'b1;
    req_valid[0]  = 1'b0;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    check("bp_idle", 64'(req_ready[0]), 64'd1);
    xact(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 2, 64'h1122334455667788, 1'b0, "r_after_bp");

    // Reset while waiting aborts the write
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b1;
    req_addr[0]  = 64'h8000_0010;
    req_wdata[0] = 64'd0;
    req_wmask[0] = 8'hFF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("rw_valid", 64'(resp_valid[0]), 64'd0);
    check("rw_rdata", resp_rdata[0], 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rw_ready", 64'(req_ready[0]), 64'd1);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = resp_valid[0];
    end
    check("rw_stale", 64'(pat), 64'd0);
    xact(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 2, 64'h1122334455667788, 1'b0, "r_after_rst");

    // LAT=1 build: single-cycle latency and back-to-back throughput
    xact(1, 1'b1, 64'h8000_0100, 64'h0123456789ABCDEF, 8'hFF, 1, 64'd0, 1'b0, "l1_w");
    xact(1, 1'b0, 64'h8000_0100, 64'd0, 8'h00, 1, 64'h0123456789ABCDEF, 1'b0, "l1_r");
    req_valid[1]  = 1'b1;
    req_wen[1]    = 1'b0;
    req_addr[1]   = 64'h8000_0100;
    resp_ready[1] = 1'b1;
    pat = '0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      pat[i] = resp_valid[1];
      if (resp_valid[1]) begin
        check("l1_b2b_rdata", resp_rdata[1], 64'h0123456789ABCDEF);
      end
    end
    req_valid[1]  = 1'b0;
    resp_ready[1] = 1'b0;
    check("l1_b2b_pattern", 64'(pat), 64'(9'b010010010));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
